// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl -- lock sequencer for the FMDLL core.
//
// Validates an N/M multiplication request, resets the DLL, lets it settle,
// then binary-searches the delay-line code from phase-detector feedback
// until the PD reports in-band LOCK_CNT times in a row at unit step.
//
// Ports:
//   clk_ext            reference clock, all logic on the rising edge
//   rst_n              synchronous active-low reset
//   cfg_valid/ready    config handshake; cfg_n (4b) / cfg_m (2b) request
//   pd_up / pd_dn      phase detector: raise / lower the delay code
//   dll_n / dll_m      multiplication factors applied to the core
//   dll_rst_n          core reset, low in IDLE and for 2 cycles in APPLY
//   dcode              delay-line control code (CODE_W bits)
//   locked             lock achieved
//   cfg_err            one-cycle pulse on an illegal config request
//   lock_fail          search exhausted (held until reconfig or reset)
//
// Build option: define FMDLL_DRIFT_TRACK_EN to keep sampling PD while
// locked and re-enter the search on DRIFT_TH same-direction samples.

module fmdll_lock_ctrl #(
    parameter int unsigned CODE_W     = 6,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned MAX_ITER   = 64,
    parameter int unsigned DRIFT_TH   = 4
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_n,
    input  logic [1:0]        cfg_m,
    input  logic              pd_up,
    input  logic              pd_dn,
    output logic [3:0]        dll_n,
    output logic [1:0]        dll_m,
    output logic              dll_rst_n,
    output logic [CODE_W-1:0] dcode,
    output logic              locked,
    output logic              cfg_err,
    output logic              lock_fail
);

    localparam int unsigned WCNT_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned LCNT_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned ECNT_W = $clog2(MAX_ITER + 1);

    localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] STEP_INIT = CODE_MID >> 1;
    localparam logic [CODE_W-1:0] STEP_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(SETTLE_CYC - 1);

    // Elaboration-time guard on parameter ranges the counters rely on.
    if (CODE_W < 2 || SETTLE_CYC < 2 || LOCK_CNT < 1 || MAX_ITER < 1 || DRIFT_TH < 1) begin : g_param_check
        $error("fmdll_lock_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_SEARCH, S_LOCKED, S_FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         dll_n_q, dll_n_d;
    logic [1:0]         dll_m_q, dll_m_d;
    logic [CODE_W-1:0]  dcode_q, dcode_d;
    logic [CODE_W-1:0]  step_q, step_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [LCNT_W-1:0]  inband_q, inband_d;
    logic [ECNT_W-1:0]  eval_q, eval_d;
    logic               cfg_err_q, cfg_err_d;

    logic               cfg_legal, move_up, move_dn, accept_win;

`ifdef FMDLL_DRIFT_TRACK_EN
    localparam int unsigned DCNT_W = $clog2(DRIFT_TH + 1);
    logic [DCNT_W-1:0]  drift_cnt_q, drift_cnt_d;
    logic               drift_up_q, drift_up_d;
`endif

    function automatic logic [CODE_W-1:0] sat_add(input logic [CODE_W-1:0] a,
                                                  input logic [CODE_W-1:0] b);
        logic [CODE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CODE_W] ? '1 : s[CODE_W-1:0];
    endfunction

    function automatic logic [CODE_W-1:0] sat_sub(input logic [CODE_W-1:0] a,
                                                  input logic [CODE_W-1:0] b);
        return (a < b) ? '0 : a - b;
    endfunction

    assign cfg_legal  = (cfg_n inside {4'd1, 4'd4, 4'd5, 4'd8, 4'd10}) && (cfg_m != 2'd0);
    assign move_up    = pd_up & ~pd_dn;
    assign move_dn    = pd_dn & ~pd_up;
    assign accept_win = (state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_FAIL);

    always_comb begin
        logic [LCNT_W-1:0] inband_nxt;
        logic [ECNT_W-1:0] eval_nxt;

        state_d    = state_q;
        dll_n_d    = dll_n_q;
        dll_m_d    = dll_m_q;
        dcode_d    = dcode_q;
        step_d     = step_q;
        wcnt_d     = wcnt_q;
        inband_d   = inband_q;
        eval_d     = eval_q;
        cfg_err_d  = 1'b0;
        inband_nxt = inband_q;
        eval_nxt   = eval_q + 1'b1;
`ifdef FMDLL_DRIFT_TRACK_EN
        drift_cnt_d = drift_cnt_q;
        drift_up_d  = drift_up_q;
`endif

        unique case (state_q)
            S_APPLY: begin
                if (wcnt_q == WCNT_W'(1)) begin
                    state_d = S_SETTLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                // Leaving with the wait counter already expired makes the
                // first evaluation happen on the first SEARCH cycle: the
                // settle period itself follows the midpoint reload.
                if (wcnt_q == WAIT_LAST) begin
                    state_d  = S_SEARCH;
                    step_d   = STEP_INIT;
                    inband_d = '0;
                    eval_d   = '0;
                end else begin
                    wcnt_d   = wcnt_q + 1'b1;
                end
            end
            S_SEARCH: begin
                if (wcnt_q == WAIT_LAST) begin
                    // Evaluations are uniformly spaced SETTLE_CYC apart.
                    wcnt_d = '0;
                    eval_d = eval_nxt;
                    if (move_up)      dcode_d = sat_add(dcode_q, step_q);
                    else if (move_dn) dcode_d = sat_sub(dcode_q, step_q);
                    if (step_q == STEP_ONE)
                        inband_nxt = (move_up || move_dn) ? '0 : inband_q + 1'b1;
                    inband_d = inband_nxt;
                    step_d   = (step_q > STEP_ONE) ? (step_q >> 1) : STEP_ONE;
                    if (inband_nxt == LCNT_W'(LOCK_CNT)) begin
                        state_d = S_LOCKED;
`ifdef FMDLL_DRIFT_TRACK_EN
                        drift_cnt_d = '0;
`endif
                    end else if (eval_nxt == ECNT_W'(MAX_ITER)) begin
                        state_d = S_FAIL;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_LOCKED: begin
`ifdef FMDLL_DRIFT_TRACK_EN
                if (wcnt_q == WAIT_LAST) begin
                    wcnt_d = '0;
                    if (move_up || move_dn) begin
                        drift_up_d  = move_up;
                        drift_cnt_d = (drift_cnt_q != '0 && drift_up_q == move_up)
                                      ? drift_cnt_q + 1'b1 : DCNT_W'(1);
                        if (drift_cnt_d == DCNT_W'(DRIFT_TH)) begin
                            dcode_d     = move_up ? sat_add(dcode_q, STEP_ONE)
                                                  : sat_sub(dcode_q, STEP_ONE);
                            state_d     = S_SEARCH;
                            step_d      = STEP_ONE;
                            inband_d    = '0;
                            eval_d      = '0;
                            drift_cnt_d = '0;
                        end
                    end else begin
                        drift_cnt_d = '0;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            default: ;
        endcase

        // Config handshake overrides any drift activity in the same cycle.
        if (accept_win && cfg_valid) begin
            if (cfg_legal) begin
                state_d = S_APPLY;
                dll_n_d = cfg_n;
                dll_m_d = cfg_m;
                dcode_d = CODE_MID;
                wcnt_d  = '0;
            end else begin
                state_d   = state_q;
                dcode_d   = dcode_q;
                wcnt_d    = wcnt_q;
                step_d    = step_q;
                inband_d  = inband_q;
                eval_d    = eval_q;
                cfg_err_d = 1'b1;
`ifdef FMDLL_DRIFT_TRACK_EN
                drift_cnt_d = drift_cnt_q;
                drift_up_d  = drift_up_q;
`endif
            end
        end
    end

    always_ff @(posedge clk_ext) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dll_n_q   <= 4'd1;
            dll_m_q   <= 2'd1;
            dcode_q   <= CODE_MID;
            step_q    <= STEP_INIT;
            wcnt_q    <= '0;
            inband_q  <= '0;
            eval_q    <= '0;
            cfg_err_q <= 1'b0;
`ifdef FMDLL_DRIFT_TRACK_EN
            drift_cnt_q <= '0;
            drift_up_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dll_n_q   <= dll_n_d;
            dll_m_q   <= dll_m_d;
            dcode_q   <= dcode_d;
            step_q    <= step_d;
            wcnt_q    <= wcnt_d;
            inband_q  <= inband_d;
            eval_q    <= eval_d;
            cfg_err_q <= cfg_err_d;
`ifdef FMDLL_DRIFT_TRACK_EN
            drift_cnt_q <= drift_cnt_d;
            drift_up_q  <= drift_up_d;
`endif
        end
    end

    assign cfg_ready = accept_win;
    assign dll_n     = dll_n_q;
    assign dll_m     = dll_m_q;
    assign dll_rst_n = (state_q != S_IDLE) && (state_q != S_APPLY);
    assign dcode     = dcode_q;
    assign locked    = (state_q == S_LOCKED);
    assign lock_fail = (state_q == S_FAIL);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb_fmdll_lock_ctrl -- self-checking bench for fmdll_lock_ctrl.
// A PD model steers the search towards a chosen target code; a
// behavioural binary-search model predicts the final code and outcome.

module tb_fmdll_lock_ctrl;

    localparam int CODE_W     = 6;
    localparam int SETTLE_CYC = 16;
    localparam int LOCK_CNT   = 8;
    localparam int MAX_ITER   = 64;
    localparam int DRIFT_TH   = 4;
    localparam int CODE_MAXV  = (1 << CODE_W) - 1;
    localparam int MID        = 1 << (CODE_W - 1);
    localparam int BOUND      = 3000;

    logic              clk_ext = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_n;
    logic [1:0]        cfg_m;
    logic              pd_up, pd_dn;
    logic [3:0]        dll_n;
    logic [1:0]        dll_m;
    logic              dll_rst_n;
    logic [CODE_W-1:0] dcode;
    logic              locked, cfg_err, lock_fail;

    int checks = 0;
    int errors = 0;
    int target = MID;
    bit force_up = 1'b0;

    fmdll_lock_ctrl #(
        .CODE_W(CODE_W), .SETTLE_CYC(SETTLE_CYC), .LOCK_CNT(LOCK_CNT),
        .MAX_ITER(MAX_ITER), .DRIFT_TH(DRIFT_TH)
    ) dut (
        .clk_ext(clk_ext), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .pd_up(pd_up), .pd_dn(pd_dn),
        .dll_n(dll_n), .dll_m(dll_m), .dll_rst_n(dll_rst_n), .dcode(dcode),
        .locked(locked), .cfg_err(cfg_err), .lock_fail(lock_fail)
    );

    always #5 clk_ext = ~clk_ext;

    // Ideal phase detector with zero tolerance.
    always_comb begin
        pd_up = force_up || (int'(dcode) < target);
        pd_dn = !force_up && (int'(dcode) > target);
    end

    task automatic tick();
        @(posedge clk_ext);
        #1;
    endtask

    function automatic bit is_legal(input int n, input int m);
        return (n == 1 || n == 4 || n == 5 || n == 8 || n == 10) && (m >= 1 && m <= 3);
    endfunction

    // Binary search as described: halving step, saturation, in-band run at unit step.
    function automatic void model_lock(input int tgt, input bit fup, output int code, output bit lk);
        int step = MID / 2;
        int run  = 0;
        bit up, dn;
        code = MID;
        lk   = 1'b0;
        for (int e = 0; e < MAX_ITER && !lk; e++) begin
            up = fup || (code < tgt);
            dn = !fup && (code > tgt);
            if (up)      code = (code + step > CODE_MAXV) ? CODE_MAXV : code + step;
            else if (dn) code = (code < step) ? 0 : code - step;
            if (step == 1) run = (up || dn) ? 0 : run + 1;
            step = (step > 1) ? step / 2 : 1;
            if (run == LOCK_CNT) lk = 1'b1;
        end
    endfunction

    task automatic send_cfg(input int n, input int m);
        cfg_n     = 4'(n);
        cfg_m     = 2'(m);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < BOUND && !locked && !lock_fail; i++) tick();
        checks++;
        if (!(locked || lock_fail)) begin
            errors++;
            $display("FAIL wait_done: no lock/fail within %0d cycles (locked=%0b lock_fail=%0b)", BOUND, locked, lock_fail);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if (dll_n !== 4'd1 || dll_m !== 2'd1 || dll_rst_n !== 1'b0 || dcode !== 6'd32 ||
            locked !== 1'b0 || cfg_err !== 1'b0 || lock_fail !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: n=%0d m=%0d rst_n=%0b dcode=%0d lk=%0b err=%0b fail=%0b rdy=%0b, required 1 1 0 32 0 0 0 1",
                     dll_n, dll_m, dll_rst_n, dcode, locked, cfg_err, lock_fail, cfg_ready);
        end
    endtask

    task automatic test_illegal();
        send_cfg(3, 2);
        checks++;
        if (cfg_err !== 1'b1 || dll_n !== 4'd1 || dll_m !== 2'd1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_pulse: err=%0b n=%0d m=%0d rdy=%0b, required 1 1 1 1", cfg_err, dll_n, dll_m, cfg_ready);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0 || cfg_ready !== 1'b1 || dll_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL illegal_one_cycle: err=%0b rdy=%0b rst_n=%0b, required 0 1 0", cfg_err, cfg_ready, dll_rst_n);
        end
    endtask

    task automatic lock_at(input string name, input int n, input int m, input int tgt);
        int  code;
        bit  lk;
        bit  fail_seen = 1'b0;
        target = tgt;
        model_lock(tgt, 1'b0, code, lk);
        send_cfg(n, m);
        checks++;
        if (dll_n !== 4'(n) || dll_m !== 2'(m) || locked !== 1'b0 || lock_fail !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: n=%0d m=%0d lk=%0b fail=%0b rdy=%0b, required %0d %0d 0 0 0",
                     name, dll_n, dll_m, locked, lock_fail, cfg_ready, n, m);
        end
        for (int i = 0; i < BOUND && !locked && !lock_fail; i++) begin
            tick();
            if (lock_fail) fail_seen = 1'b1;
        end
        checks++;
        if (locked !== lk || dcode !== 6'(code) || fail_seen || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_lock: locked=%0b dcode=%0d fail_seen=%0b rdy=%0b, required %0b %0d 0 1",
                     name, locked, dcode, fail_seen, cfg_ready, lk, code);
        end
    endtask

    task automatic test_lock();
        target = 45;
        send_cfg(10, 3);
        checks++;
        if (dll_n !== 4'd10 || dll_m !== 2'd3 || dll_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL t3_apply: n=%0d m=%0d rst_n=%0b, required 10 3 0", dll_n, dll_m, dll_rst_n);
        end
        tick();
        checks++;
        if (dll_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL t3_rst_cycle2: rst_n=%0b, required 0", dll_rst_n);
        end
        tick();
        checks++;
        if (dll_rst_n !== 1'b1 || dcode !== 6'd32) begin
            errors++;
            $display("FAIL t3_release: rst_n=%0b dcode=%0d, required 1 32", dll_rst_n, dcode);
        end
        wait_done();
        checks++;
        if (locked !== 1'b1 || dcode !== 6'd45) begin
            errors++;
            $display("FAIL t3_lock: locked=%0b dcode=%0d, required 1 45", locked, dcode);
        end
    endtask

    task automatic test_reconfig();
        lock_at("t5", 4, 2, 20);
    endtask

    task automatic test_drift();
        bit ok = 1'b1;
        lock_at("t6_pre", 5, 1, 45);
        target = 47;
`ifdef FMDLL_DRIFT_TRACK_EN
        for (int i = 0; i < (DRIFT_TH + 3) * SETTLE_CYC && locked; i++) tick();
        checks++;
        if (locked !== 1'b0 || dcode !== 6'd46) begin
            errors++;
            $display("FAIL t6_drop: locked=%0b dcode=%0d, required 0 46", locked, dcode);
        end
        wait_done();
        checks++;
        if (locked !== 1'b1 || dcode !== 6'd47) begin
            errors++;
            $display("FAIL t6_relock: locked=%0b dcode=%0d, required 1 47", locked, dcode);
        end
`else
        for (int i = 0; i < (DRIFT_TH + 4) * SETTLE_CYC; i++) begin
            tick();
            if (locked !== 1'b1 || dcode !== 6'd45) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t6_hold: locked=%0b dcode=%0d, required 1 45 throughout", locked, dcode);
        end
`endif
    endtask

    task automatic test_fail();
        int code;
        bit lk;
        bit lock_seen = 1'b0;
        model_lock(0, 1'b1, code, lk);
        force_up = 1'b1;
        send_cfg(8, 2);
        for (int i = 0; i < BOUND && !lock_fail; i++) begin
            tick();
            if (locked) lock_seen = 1'b1;
        end
        checks++;
        if (lock_fail !== !lk || dcode !== 6'(code) || cfg_ready !== 1'b1 || lock_seen ||
            locked !== 1'b0 || dll_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL t4_fail: fail=%0b dcode=%0d rdy=%0b lock_seen=%0b lk=%0b rst_n=%0b, required %0b %0d 1 0 0 1",
                     lock_fail, dcode, cfg_ready, lock_seen, locked, dll_rst_n, !lk, code);
        end
        repeat (3 * SETTLE_CYC) tick();
        checks++;
        if (lock_fail !== 1'b1 || dcode !== 6'd63) begin
            errors++;
            $display("FAIL t4_sticky: fail=%0b dcode=%0d, required 1 63", lock_fail, dcode);
        end
        force_up = 1'b0;
    endtask

    task automatic test_random();
        int n, m, code0;
        for (int it = 0; it < 6; it++) begin
            n = 0;
            case ($urandom_range(0, 4))
                0: n = 1;  1: n = 4;  2: n = 5;  3: n = 8;  default: n = 10;
            endcase
            m = int'($urandom_range(1, 3));
            lock_at("rand", n, m, int'($urandom_range(0, CODE_MAXV)));
            code0 = int'(dcode);
            do begin
                n = int'($urandom_range(0, 15));
                m = int'($urandom_range(0, 3));
            end while (is_legal(n, m));
            send_cfg(n, m);
            checks++;
            if (cfg_err !== 1'b1 || locked !== 1'b1 || int'(dcode) != code0 || dll_n === 4'(n) && n != int'(dll_n)) begin
                errors++;
                $display("FAIL rand_illegal: err=%0b locked=%0b dcode=%0d, required 1 1 %0d", cfg_err, locked, dcode, code0);
            end
            tick();
            checks++;
            if (cfg_err !== 1'b0 || locked !== 1'b1) begin
                errors++;
                $display("FAIL rand_illegal_end: err=%0b locked=%0b, required 0 1", cfg_err, locked);
            end
        end
    endtask

    task automatic test_busy_ignore();
        target = 10;
        send_cfg(1, 1);
        repeat (25) tick();
        send_cfg(10, 3);
        checks++;
        if (dll_n !== 4'd1 || dll_m !== 2'd1 || cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: n=%0d m=%0d err=%0b rdy=%0b, required 1 1 0 0", dll_n, dll_m, cfg_err, cfg_ready);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        checks++;
        if (dcode !== 6'd32 || dll_rst_n !== 1'b0 || locked !== 1'b0 || cfg_ready !== 1'b1 ||
            dll_n !== 4'd1 || dll_m !== 2'd1 || lock_fail !== 1'b0) begin
            errors++;
            $display("FAIL t1_reset: dcode=%0d rst_n=%0b lk=%0b rdy=%0b n=%0d m=%0d fail=%0b, required 32 0 0 1 1 1 0",
                     dcode, dll_rst_n, locked, cfg_ready, dll_n, dll_m, lock_fail);
        end
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (dll_rst_n !== 1'b0 || cfg_ready !== 1'b1 || dcode !== 6'd32) begin
            errors++;
            $display("FAIL t1_idle: rst_n=%0b rdy=%0b dcode=%0d, required 0 1 32", dll_rst_n, cfg_ready, dcode);
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_lock();
        test_reconfig();
        test_drift();
        test_fail();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
